// File: rtl/pe_matrix_expectation_ctrl_pkg.sv
// Shared types and widths for the sigma-point expectation sequencer.
package pe_matrix_expectation_ctrl_pkg;

    localparam int unsigned SIGMA_W  = 32;
    localparam int unsigned WEIGHT_W = 32;
    localparam int unsigned ACC_W    = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width needed to hold a pair count from 0 up to n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pe_matrix_expectation_comb.sv
// Combinational per-element multiply-accumulate: mac_i = run_sum_i + weight*sigma_i (wrapping).
module pe_matrix_expectation_comb
    import pe_matrix_expectation_ctrl_pkg::*;
#(
    parameter int unsigned DIM_SIGMA = 5
) (
    input  logic [WEIGHT_W-1:0]          weight,
    input  logic [SIGMA_W*DIM_SIGMA-1:0] sigma,
    input  logic [ACC_W*DIM_SIGMA-1:0]   run_sum,
    output logic [ACC_W*DIM_SIGMA-1:0]   mac_out
);

    logic signed [ACC_W-1:0] w_weight_ext;

    assign w_weight_ext = ACC_W'($signed(weight));

    for (genvar g = 0; g < int'(DIM_SIGMA); g++) begin : g_elem
        logic signed [ACC_W-1:0] w_sigma_ext;
        logic signed [ACC_W-1:0] w_prod;

        // Operands sign-extended to the accumulator width so the product is exact mod 2^64.
        assign w_sigma_ext = ACC_W'($signed(sigma[SIGMA_W*g +: SIGMA_W]));
        assign w_prod      = w_weight_ext * w_sigma_ext;
        assign mac_out[ACC_W*g +: ACC_W] = run_sum[ACC_W*g +: ACC_W] + w_prod;
    end

endmodule

// File: rtl/pe_matrix_expectation_ctrl.sv
// Sequencer that absorbs N_SIGMA weight/sigma pairs into a running sum and presents the mean.
module pe_matrix_expectation_ctrl
    import pe_matrix_expectation_ctrl_pkg::*;
#(
    parameter int unsigned DIM_SIGMA = 5,
    parameter int unsigned N_SIGMA   = 11
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WEIGHT_W-1:0]             weight,
    input  logic [SIGMA_W*DIM_SIGMA-1:0]    sigma,
    output logic [ACC_W*DIM_SIGMA-1:0]      mean,
    output logic                            mean_valid,
    input  logic                            mean_ready,
    output logic                            busy,
    output logic [cnt_w(N_SIGMA)-1:0]       count
);

    localparam int unsigned CNT_W = cnt_w(N_SIGMA);

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [ACC_W*DIM_SIGMA-1:0]   r_acc;
    logic [ACC_W*DIM_SIGMA-1:0]   w_acc_nxt;
    logic [ACC_W*DIM_SIGMA-1:0]   w_mac_out;
    logic [CNT_W-1:0]             r_count;
    logic [CNT_W-1:0]             w_count_nxt;
    logic [CNT_W-1:0]             w_count_inc;
    logic                         r_in_ready;
    logic                         r_mean_valid;
    logic                         r_busy;

    pe_matrix_expectation_comb #(
        .DIM_SIGMA (DIM_SIGMA)
    ) u_mac (
        .weight  (weight),
        .sigma   (sigma),
        .run_sum (r_acc),
        .mac_out (w_mac_out)
    );

    assign w_count_inc = r_count + CNT_W'(1);

    // Next-state, accumulator and counter update.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_count_nxt = r_count;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = ACCUM;
                    w_acc_nxt   = '0;
                    w_count_nxt = '0;
                end
            end
            ACCUM: begin
                if (in_valid && r_in_ready) begin
                    w_acc_nxt   = w_mac_out;
                    w_count_nxt = w_count_inc;
                    if (w_count_inc == CNT_W'(N_SIGMA)) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                // start alongside the mean handshake chains straight into the next expectation.
                if (mean_ready) begin
                    if (start) begin
                        w_state_nxt = ACCUM;
                        w_acc_nxt   = '0;
                        w_count_nxt = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Handshake flags are registered off the next state so they track r_state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_acc        <= '0;
            r_count      <= '0;
            r_in_ready   <= 1'b0;
            r_mean_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_acc        <= w_acc_nxt;
            r_count      <= w_count_nxt;
            r_in_ready   <= (w_state_nxt == ACCUM);
            r_mean_valid <= (w_state_nxt == DONE);
            r_busy       <= (w_state_nxt != IDLE);
        end
    end

    assign in_ready   = r_in_ready;
    assign mean_valid = r_mean_valid;
    assign busy       = r_busy;
    assign count      = r_count;
    assign mean       = r_acc;

endmodule

// File: tb/tb_pe_matrix_expectation_ctrl.sv
// Scoreboard bench for pe_matrix_expectation_ctrl using directed, hand-computed vectors.
module tb_pe_matrix_expectation_ctrl;

    localparam int DIM = 5;
    localparam int NS  = 11;
    localparam int CW  = $clog2(NS + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       weight;
    logic [32*DIM-1:0] sigma;
    logic [64*DIM-1:0] mean;
    logic              mean_valid;
    logic              mean_ready;
    logic              busy;
    logic [CW-1:0]     count;

    int                errors = 0;
    int                checks = 0;
    int unsigned       cyc_cnt = 0;
    int unsigned       t0;
    logic [64*DIM-1:0] exp_q[$];
    logic [64*DIM-1:0] mon_exp;
    logic [64*DIM-1:0] v22, v11, vsgn;

    pe_matrix_expectation_ctrl #(.DIM_SIGMA(DIM), .N_SIGMA(NS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .weight     (weight),
        .sigma      (sigma),
        .mean       (mean),
        .mean_valid (mean_valid),
        .mean_ready (mean_ready),
        .busy       (busy),
        .count      (count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    function automatic logic [64*DIM-1:0] mk(input longint e0, input longint e1, input longint er);
        logic [64*DIM-1:0] v;
        v = '0;
        v[63:0]   = 64'(e0);
        v[127:64] = 64'(e1);
        for (int i = 2; i < DIM; i++) v[64*i +: 64] = 64'(er);
        return v;
    endfunction

    function automatic logic [32*DIM-1:0] sig(input int e0, input int e1, input int er);
        logic [32*DIM-1:0] v;
        v = '0;
        v[31:0]  = 32'(e0);
        v[63:32] = 32'(e1);
        for (int i = 2; i < DIM; i++) v[32*i +: 32] = 32'(er);
        return v;
    endfunction

    // Monitor: every mean handshake is checked against the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && mean_valid && mean_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_mean: got mean_valid=1 required no pending mean");
            end else begin
                mon_exp = exp_q.pop_front();
                for (int i = 0; i < DIM; i++)
                    chk($sformatf("mean_elem%0d", i), mean[64*i +: 64], mon_exp[64*i +: 64]);
                chk("done_count", 64'(count), 64'(NS));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        t0    = cyc_cnt;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int w, input logic [32*DIM-1:0] s);
        int n;
        in_valid = 1'b1;
        weight   = 32'(w);
        sigma    = s;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!mean_valid && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("mean_valid_timeout", 64'(mean_valid), 64'd1);
    endtask

    task automatic take(input int hold, input logic [64*DIM-1:0] expv, input logic restart);
        for (int h = 0; h < hold; h++) begin
            mean_ready = 1'b0;
            chk("hold_valid", 64'(mean_valid), 64'd1);
            chk("hold_elem0", mean[63:0], expv[63:0]);
            chk("hold_elem1", mean[127:64], expv[127:64]);
            tick();
        end
        mean_ready = 1'b1;
        start      = restart;
        tick();
        mean_ready = 1'b0;
        start      = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; weight = '0; sigma = '0; mean_ready = 1'b0;
        v22  = mk(22, 22, 22);
        v11  = mk(11, 11, 11);
        vsgn = mk(65, -91, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state, and in_valid ignored while idle.
        in_valid = 1'b1; weight = 32'd9; sigma = sig(9, 9, 9);
        tick(); tick();
        in_valid = 1'b0;
        chk("idle_in_ready", 64'(in_ready), 64'd0);
        chk("idle_count", 64'(count), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_mean", mean[63:0], 64'd0);

        // Basic sum with in_valid held high.
        exp_q.push_back(v22);
        do_start();
        chk("accum_busy", 64'(busy), 64'd1);
        for (int k = 0; k < NS; k++) send(1, sig(2, 2, 2));
        chk("latency", 64'(cyc_cnt - t0), 64'd12);
        chk("done_valid", 64'(mean_valid), 64'd1);
        chk("done_in_ready", 64'(in_ready), 64'd0);
        chk("done_busy", 64'(busy), 64'd1);
        take(2, v22, 1'b0);
        chk("post_valid", 64'(mean_valid), 64'd0);
        chk("post_busy", 64'(busy), 64'd0);

        // Stalls: acc and count hold on idle cycles.
        exp_q.push_back(v22);
        do_start();
        for (int k = 0; k < NS; k++) begin
            in_valid = 1'b0;
            tick();
            chk("stall_acc0", mean[63:0], 64'(2 * k));
            chk("stall_count", 64'(count), 64'(k));
            send(1, sig(2, 2, 2));
        end
        wait_valid();
        take(0, v22, 1'b0);

        // Signed weights, mean held while consumer stalls.
        exp_q.push_back(vsgn);
        do_start();
        for (int k = 0; k < NS; k++) send((k % 2 == 0) ? 3 : -1, sig(5, -7, 0));
        wait_valid();
        take(10, vsgn, 1'b0);

        // Back-to-back: handshake and start together, then start pulse mid-accumulation.
        exp_q.push_back(v22);
        do_start();
        for (int k = 0; k < NS; k++) send(1, sig(2, 2, 2));
        wait_valid();
        exp_q.push_back(v22);
        take(0, v22, 1'b1);
        chk("b2b_in_ready", 64'(in_ready), 64'd1);
        chk("b2b_valid", 64'(mean_valid), 64'd0);
        chk("b2b_count", 64'(count), 64'd0);
        chk("b2b_acc0", mean[63:0], 64'd0);
        for (int k = 0; k < NS; k++) begin
            start = (k == 3 || k == 7);
            send(2, sig(1, 1, 1));
            start = 1'b0;
            chk("b2b_count_mono", 64'(count), 64'(k + 1));
        end
        wait_valid();
        take(0, v22, 1'b0);

        // Abort mid-accumulation with an asynchronous reset.
        do_start();
        for (int k = 0; k < 4; k++) send(5, sig(7, 7, 7));
        #2;
        rst = 1'b1;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(mean_valid), 64'd0);
        chk("abort_count", 64'(count), 64'd0);
        for (int i = 0; i < DIM; i++) chk("abort_mean", mean[64*i +: 64], 64'd0);
        tick();
        rst = 1'b0;
        tick();
        exp_q.push_back(v11);
        do_start();
        for (int k = 0; k < NS; k++) send(1, sig(1, 1, 1));
        wait_valid();
        take(0, v11, 1'b0);

        for (int n = 0; n < 10 && exp_q.size() != 0; n++) tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
